// File: rtl/store_rmw_seq.sv
// Store sequencer: turns byte/half/word store requests into RAM accesses.
// Sub-word stores do a read-modify-write through an external merge stage.
module store_rmw_seq #(
  parameter int         ADDR_W   = 32,
  parameter logic [1:0] STORE_SB = 2'd0,
  parameter logic [1:0] STORE_SH = 2'd1,
  parameter logic [1:0] STORE_SW = 2'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_type,
  output logic              st_done,
  output logic              st_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  output logic [31:0]       mrg_orig,
  output logic [31:0]       mrg_ram,
  output logic [1:0]        mrg_type,
  output logic [1:0]        mrg_addr_low,
  input  logic [31:0]       mrg_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        type_q, type_d;
  logic [31:0]       mrg_ram_q, mrg_ram_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_re_q, ram_re_d;
  logic              ram_we_q, ram_we_d;
  logic              st_done_q, st_done_d;
  logic              st_err_q, st_err_d;
  logic              st_ready_q, st_ready_d;

  logic [1:0]        type_in;
  logic [ADDR_W-1:0] word_addr_in;
  logic              misaligned_in;
  logic              accept;

  // Encoding 3 is folded into a full-word store before any decision is made.
  assign type_in       = (st_type == 2'd3) ? STORE_SW : st_type;
  assign word_addr_in  = {st_addr[ADDR_W-1:2], 2'b00};
  assign misaligned_in = ((type_in == STORE_SH) && st_addr[0]) ||
                         ((type_in == STORE_SW) && (st_addr[1:0] != 2'b00));
  assign accept        = st_valid && st_ready_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    type_d     = type_q;
    mrg_ram_d  = mrg_ram_q;
    ram_addr_d = ram_addr_q;
    ram_re_d   = 1'b0;
    ram_we_d   = 1'b0;
    st_done_d  = 1'b0;
    st_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = st_addr;
          data_d = st_data;
          type_d = type_in;
          if (misaligned_in) begin
            st_err_d = 1'b1;
          end else if (type_in == STORE_SW) begin
            state_d    = WRITE;
            ram_we_d   = 1'b1;
            st_done_d  = 1'b1;
            ram_addr_d = word_addr_in;
          end else if ((type_in == STORE_SB) || (type_in == STORE_SH)) begin
            state_d    = READ;
            ram_re_d   = 1'b1;
            ram_addr_d = word_addr_in;
          end
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // RAM data returns here; the write address is already on ram_addr.
        mrg_ram_d = ram_rdata;
        state_d   = WRITE;
        ram_we_d  = 1'b1;
        st_done_d = 1'b1;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    st_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      type_q     <= '0;
      mrg_ram_q  <= '0;
      ram_addr_q <= '0;
      ram_re_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      st_done_q  <= 1'b0;
      st_err_q   <= 1'b0;
      st_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      type_q     <= type_d;
      mrg_ram_q  <= mrg_ram_d;
      ram_addr_q <= ram_addr_d;
      ram_re_q   <= ram_re_d;
      ram_we_q   <= ram_we_d;
      st_done_q  <= st_done_d;
      st_err_q   <= st_err_d;
      st_ready_q <= st_ready_d;
    end
  end

  assign st_ready     = st_ready_q;
  assign st_done      = st_done_q;
  assign st_err       = st_err_q;
  assign ram_addr     = ram_addr_q;
  assign ram_re       = ram_re_q;
  assign ram_we       = ram_we_q;
  assign mrg_orig     = data_q;
  assign mrg_ram      = mrg_ram_q;
  assign mrg_type     = type_q;
  assign mrg_addr_low = addr_q[1:0];

  // Full-word stores bypass the merge stage; write data is zero when idle.
  assign ram_wdata = !ram_we_q ? 32'h0 :
                     (type_q == STORE_SW) ? data_q : mrg_result;

endmodule

// File: tb/tb_store_rmw_seq.sv
// Scoreboard bench for store_rmw_seq with a one-cycle-latency RAM and a
// little-endian merge stage model.
module tb_store_rmw_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_type;
  logic        st_done;
  logic        st_err;
  logic [31:0] ram_addr;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] mrg_orig;
  logic [31:0] mrg_ram;
  logic [1:0]  mrg_type;
  logic [1:0]  mrg_addr_low;
  logic [31:0] mrg_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] ram;
    bit          chk_ram;
    int          cyc;
  } wr_exp_t;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } rd_exp_t;

  wr_exp_t wq[$];
  rd_exp_t rq[$];
  int      eq[$];

  logic [31:0] mem    [0:1023];
  logic [31:0] sh_mem [0:1023];

  store_rmw_seq #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_type      (st_type),
    .st_done      (st_done),
    .st_err       (st_err),
    .ram_addr     (ram_addr),
    .ram_re       (ram_re),
    .ram_rdata    (ram_rdata),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .mrg_orig     (mrg_orig),
    .mrg_ram      (mrg_ram),
    .mrg_type     (mrg_type),
    .mrg_addr_low (mrg_addr_low),
    .mrg_result   (mrg_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mergeWord(input logic [31:0] w, input logic [31:0] d,
                                            input logic [1:0] t, input logic [1:0] lo);
    logic [31:0] r;
    r = w;
    case (t)
      2'd0:    r[{lo, 3'b000} +: 8] = d[7:0];
      2'd1:    r[{lo[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb mrg_result = mergeWord(mrg_ram, mrg_orig, mrg_type, mrg_addr_low);

  // RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_addr[11:2]];
    if (ram_we) mem[ram_addr[11:2]] <= ram_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries as strobes appear.
  bit prev_re = 1'b0;
  always @(negedge clk) begin
    if (prev_re) checkOutput("rdy_wait", st_ready, 1'b0);
    prev_re = ram_re;
    if (ram_re || ram_we) begin
      checkOutput("re_we_excl", ram_re & ram_we, 1'b0);
      checkOutput("rdy_busy", st_ready, 1'b0);
    end
    if (ram_re) begin
      if (rq.size() == 0) checkOutput("re_unexp", ram_re, 1'b0);
      else begin
        rd_exp_t r;
        r = rq.pop_front();
        checkOutput("re_addr", ram_addr, r.addr);
        checkOutput("re_cycle", cyc, r.cyc);
      end
    end
    if (ram_we) begin
      if (wq.size() == 0) checkOutput("we_unexp", ram_we, 1'b0);
      else begin
        wr_exp_t w;
        w = wq.pop_front();
        checkOutput("we_addr", ram_addr, w.addr);
        checkOutput("we_data", ram_wdata, w.data);
        checkOutput("we_cycle", cyc, w.cyc);
        checkOutput("we_done", st_done, 1'b1);
        if (w.chk_ram) checkOutput("mrg_ram", mrg_ram, w.ram);
      end
    end else begin
      checkOutput("done_idle", st_done, 1'b0);
    end
    if (st_err) begin
      if (eq.size() == 0) checkOutput("err_unexp", st_err, 1'b0);
      else checkOutput("err_cycle", cyc, eq.pop_front());
    end
  end

  // Drives one request starting at a negedge and returns one cycle after its
  // accept, leaving st_valid high so a following call can be back-to-back.
  task automatic applyStimulus(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                               input bit abort, output int acc);
    logic [1:0]  te;
    logic [31:0] word;
    bit          mis;
    wr_exp_t     w;
    rd_exp_t     r;
    int          n;
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
    n = 0;
    while (!st_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready) begin
      checkOutput("rdy_timeout", st_ready, 1'b1);
      st_valid = 1'b0;
      acc = -1;
      return;
    end
    acc  = cyc;
    te   = (t == 2'd3) ? 2'd2 : t;
    word = {a[31:2], 2'b00};
    mis  = ((te == 2'd1) && a[0]) || ((te == 2'd2) && (a[1:0] != 2'b00));
    if (mis) begin
      eq.push_back(acc + 1);
    end else if (te == 2'd2) begin
      w.addr = word; w.data = d; w.ram = 32'h0; w.chk_ram = 1'b0; w.cyc = acc + 1;
      if (!abort) begin
        wq.push_back(w);
        sh_mem[word[11:2]] = d;
      end
    end else begin
      r.addr = word; r.cyc = acc + 1;
      rq.push_back(r);
      w.addr = word;
      w.ram  = sh_mem[word[11:2]];
      w.data = mergeWord(w.ram, d, te, a[1:0]);
      w.chk_ram = 1'b1;
      w.cyc  = acc + 3;
      if (!abort) begin
        wq.push_back(w);
        sh_mem[word[11:2]] = w.data;
      end
    end
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    st_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int acc1, acc2;
  logic [9:0] ridx;
  logic [1:0] rlo;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 32'h9E3779B9 * (i + 1);
      sh_mem[i] = 32'h9E3779B9 * (i + 1);
    end
    mem[10'h080] = 32'h11223344; sh_mem[10'h080] = 32'h11223344;
    mem[10'h0C0] = 32'h11223344; sh_mem[10'h0C0] = 32'h11223344;

    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_type = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", st_ready, 1'b1);
    checkOutput("rst_we", ram_we, 1'b0);
    checkOutput("rst_re", ram_re, 1'b0);
    checkOutput("rst_err", st_err, 1'b0);
    checkOutput("rst_addr", ram_addr, 32'h0);
    checkOutput("rst_wdata", ram_wdata, 32'h0);
    checkOutput("rst_orig", mrg_orig, 32'h0);
    checkOutput("rst_mram", mrg_ram, 32'h0);
    checkOutput("rst_type", {30'h0, mrg_type}, 32'h0);
    checkOutput("rst_low", {30'h0, mrg_addr_low}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed stores");
    applyStimulus(2'd2, 32'h100, 32'hDEADBEEF, 1'b0, acc1);
    idleCycles(3);
    checkOutput("addr_hold", ram_addr, 32'h100);
    checkOutput("mem_sw", mem[10'h040], 32'hDEADBEEF);

    applyStimulus(2'd0, 32'h203, 32'h000000AA, 1'b0, acc1);
    checkOutput("sb_orig", mrg_orig, 32'h000000AA);
    checkOutput("sb_low", {30'h0, mrg_addr_low}, 32'h3);
    idleCycles(5);
    checkOutput("mem_sb", mem[10'h080], 32'hAA223344);

    applyStimulus(2'd1, 32'h302, 32'h0000BEEF, 1'b0, acc1);
    idleCycles(5);
    checkOutput("mem_sh", mem[10'h0C0], 32'hBEEF3344);

    $display("[TB] misaligned stores");
    applyStimulus(2'd1, 32'h301, 32'h1234, 1'b0, acc1);
    idleCycles(2);
    applyStimulus(2'd2, 32'h102, 32'h55667788, 1'b0, acc1);
    idleCycles(2);
    applyStimulus(2'd3, 32'h101, 32'h55667788, 1'b0, acc1);
    idleCycles(2);
    checkOutput("type3_latch", {30'h0, mrg_type}, 32'h2);

    $display("[TB] reset during WAIT");
    applyStimulus(2'd0, 32'h201, 32'h000000CC, 1'b1, acc1);
    st_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", st_ready, 1'b1);
    checkOutput("abort_we", ram_we, 1'b0);
    checkOutput("abort_mram", mrg_ram, 32'h0);
    checkOutput("abort_orig", mrg_orig, 32'h0);
    rst_n = 1'b1;
    idleCycles(5);
    checkOutput("abort_mem", mem[10'h080], 32'hAA223344);

    $display("[TB] back-to-back");
    applyStimulus(2'd2, 32'h40, 32'hCAFEF00D, 1'b0, acc1);
    applyStimulus(2'd0, 32'h45, 32'h00000077, 1'b0, acc2);
    checkOutput("b2b_gap", acc2 - acc1, 32'd2);
    applyStimulus(2'd1, 32'h4A, 32'h0000A5A5, 1'b0, acc1);
    checkOutput("b2b_gap_sb", acc1 - acc2, 32'd4);
    idleCycles(5);

    $display("[TB] random stores");
    for (int i = 0; i < 200; i++) begin
      ridx = 10'($urandom_range(0, 1023));
      rlo  = 2'($urandom_range(0, 3));
      applyStimulus(2'($urandom_range(0, 3)), {20'h0, ridx, rlo}, $urandom, 1'b0, acc1);
      if ($urandom_range(0, 2) != 0) idleCycles($urandom_range(1, 3));
    end
    idleCycles(8);

    checkOutput("wq_empty", wq.size(), 32'd0);
    checkOutput("rq_empty", rq.size(), 32'd0);
    checkOutput("eq_empty", eq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
